// File: rtl/rom_emu_pkg.sv
// Shared definitions for the ROM emulator host controller:
// command codes, mode bit positions and the host cycle FSM states.
package rom_emu_pkg;

  localparam logic [2:0] CMD_RESET    = 3'd0;
  localparam logic [2:0] CMD_SET_ADDR = 3'd1;
  localparam logic [2:0] CMD_INC_ADDR = 3'd2;
  localparam logic [2:0] CMD_SET_DATA = 3'd3;
  localparam logic [2:0] CMD_GET_DATA = 3'd4;
  localparam logic [2:0] CMD_SET_MODE = 3'd5;
  localparam logic [2:0] CMD_NOP0     = 3'd6;
  localparam logic [2:0] CMD_NOP1     = 3'd7;

  localparam int MODE_TGT  = 0;
  localparam int MODE_AINC = 1;
  localparam int MODE_WP   = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WR   = 2'd1,
    REC  = 2'd2,
    RD   = 2'd3
  } state_t;

endpackage

// File: rtl/rom_emu_ctrl_p_if.sv
// Host nibble command port of the ROM emulator controller.
// The host side is the master; the controller is the slave.
interface rom_emu_ctrl_p_if #(
  parameter int NIB_W = 4
);
  logic             i_HStb;
  logic [2:0]       i_HCmd;
  logic [NIB_W-1:0] i_HData;
  logic [NIB_W-1:0] o_HData;
  logic             o_HBusy;
  logic             o_HErr;

  modport master (
    output i_HStb, i_HCmd, i_HData,
    input  o_HData, o_HBusy, o_HErr
  );

  modport slave (
    input  i_HStb, i_HCmd, i_HData,
    output o_HData, o_HBusy, o_HErr
  );
endinterface

// File: rtl/rom_emu_nib_shift.sv
// Nibble-addressed register: writes or presents one nibble at a time under a
// wrapping nibble counter, with optional parallel load of the whole word.
module rom_emu_nib_shift #(
  parameter int TOTAL_W = 16,
  parameter int NIB_W   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               clr_idx,
  input  logic               shift_en,
  input  logic               step,
  input  logic               load,
  input  logic [NIB_W-1:0]   nib_in,
  input  logic [TOTAL_W-1:0] load_val,
  output logic [TOTAL_W-1:0] value,
  output logic [NIB_W-1:0]   nib_out,
  output logic               last,
  output logic               idx_zero
);
  localparam int N  = TOTAL_W / NIB_W;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  logic [IW-1:0] idx;

  // Parallel load wins over a nibble write; the counter moves independently.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value <= '0;
      idx   <= '0;
    end else if (clr) begin
      value <= '0;
      idx   <= '0;
    end else begin
      if (load)
        value <= load_val;
      else if (shift_en)
        value[idx*NIB_W +: NIB_W] <= nib_in;
      if (clr_idx)
        idx <= '0;
      else if (shift_en || step)
        idx <= last ? '0 : idx + 1'b1;
    end
  end

  assign nib_out  = value[idx*NIB_W +: NIB_W];
  assign last     = (idx == IW'(N - 1));
  assign idx_zero = (idx == '0);

endmodule

// File: rtl/rom_emu_ctrl_p.sv
// Host-side controller for the ROM emulator SRAM: nibble-serial host access
// with timed SRAM cycles, plus a pass-through path when the target owns the SRAM.
module rom_emu_ctrl_p
  import rom_emu_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8,
  parameter int NIB_W  = 4,
  parameter int RD_CYC = 2,
  parameter int WR_CYC = 2
) (
  input  logic              i_HClk,
  input  logic              i_Reset,
  rom_emu_ctrl_p_if.slave   host,
  input  logic [ADDR_W-1:0] i_TAddr,
  inout  wire  [DATA_W-1:0] io_TData,
  input  logic              i_nTOE,
  input  logic              i_nTWE,
  output logic [ADDR_W-1:0] o_RAddr,
  inout  wire  [DATA_W-1:0] io_RData,
  output logic              o_nROE,
  output logic              o_nRWE,
  output logic              o_nReset
);
  localparam int CNT_MAX = (RD_CYC > WR_CYC) ? RD_CYC : WR_CYC;
  localparam int CW      = $clog2(CNT_MAX + 1);

  state_t            state, state_nx;
  logic [CW-1:0]     cnt, cnt_nx;
  logic [2:0]        mode;
  logic              herr;
  logic [NIB_W-1:0]  hdata;

  logic [2:0]        cmd;
  logic              idle, tgt, accept, host_ok, soft_rst, err_set;
  logic              set_addr, inc_addr, set_data, get_data, get_shift;
  logic              rd_done, addr_inc;
  logic [ADDR_W-1:0] a_val;
  logic [DATA_W-1:0] w_val, r_val, r_out;
  logic [NIB_W-1:0]  a_nib, w_nib, r_nib;
  logic              a_last, a_zero, w_last, w_zero, r_last, r_zero;
  logic              r_drive, t_drive;
  logic              unused_bits;

  assign cmd      = host.i_HCmd;
  assign idle     = (state == IDLE);
  assign tgt      = mode[MODE_TGT];
  assign accept   = host.i_HStb && idle;
  assign host_ok  = accept && !tgt;
  assign soft_rst = accept && (cmd == CMD_RESET);
  assign set_addr = host_ok && (cmd == CMD_SET_ADDR);
  assign inc_addr = host_ok && (cmd == CMD_INC_ADDR);
  assign set_data = host_ok && (cmd == CMD_SET_DATA);
  assign get_data = host_ok && (cmd == CMD_GET_DATA);
  assign get_shift = get_data && !r_zero;
  assign rd_done  = (state == RD) && (cnt == CW'(RD_CYC - 1));
  // Target mode locks out every command that would touch the SRAM.
  assign err_set  = host.i_HStb && (!idle ||
                    (tgt && (cmd inside {CMD_SET_ADDR, CMD_INC_ADDR,
                                         CMD_SET_DATA, CMD_GET_DATA})));
  assign addr_inc = inc_addr
                 || ((state == REC) && mode[MODE_AINC])
                 || (get_shift && r_last && mode[MODE_AINC]);

  rom_emu_nib_shift #(.TOTAL_W(ADDR_W), .NIB_W(NIB_W)) u_addr (
    .clk(i_HClk), .rst(i_Reset), .clr(soft_rst), .clr_idx(1'b0),
    .shift_en(set_addr), .step(1'b0), .load(addr_inc),
    .nib_in(host.i_HData), .load_val(a_val + ADDR_W'(1)),
    .value(a_val), .nib_out(a_nib), .last(a_last), .idx_zero(a_zero)
  );

  rom_emu_nib_shift #(.TOTAL_W(DATA_W), .NIB_W(NIB_W)) u_wbuf (
    .clk(i_HClk), .rst(i_Reset), .clr(soft_rst), .clr_idx(set_addr),
    .shift_en(set_data), .step(1'b0), .load(1'b0),
    .nib_in(host.i_HData), .load_val('0),
    .value(w_val), .nib_out(w_nib), .last(w_last), .idx_zero(w_zero)
  );

  // The read buffer is filled in one go; its counter then walks the nibbles out.
  rom_emu_nib_shift #(.TOTAL_W(DATA_W), .NIB_W(NIB_W)) u_rbuf (
    .clk(i_HClk), .rst(i_Reset), .clr(soft_rst), .clr_idx(set_addr),
    .shift_en(1'b0), .step(rd_done || get_shift), .load(rd_done),
    .nib_in('0), .load_val(io_RData),
    .value(r_val), .nib_out(r_nib), .last(r_last), .idx_zero(r_zero)
  );

  assign unused_bits = ^{a_nib, a_last, a_zero, w_nib, w_zero, r_val};

  always_ff @(posedge i_HClk or posedge i_Reset) begin
    if (i_Reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      IDLE: begin
        if (set_data && w_last) begin
          state_nx = WR;
          cnt_nx   = '0;
        end else if (get_data && r_zero) begin
          state_nx = RD;
          cnt_nx   = '0;
        end
      end
      WR: begin
        if (cnt == CW'(WR_CYC - 1))
          state_nx = REC;
        else
          cnt_nx = cnt + 1'b1;
      end
      REC: state_nx = IDLE;
      RD: begin
        if (cnt == CW'(RD_CYC - 1))
          state_nx = IDLE;
        else
          cnt_nx = cnt + 1'b1;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge i_HClk or posedge i_Reset) begin
    if (i_Reset) begin
      mode  <= '0;
      herr  <= 1'b0;
      hdata <= '0;
    end else if (soft_rst) begin
      mode  <= '0;
      herr  <= 1'b0;
      hdata <= '0;
    end else begin
      if (err_set)
        herr <= 1'b1;
      if (accept && (cmd == CMD_SET_MODE))
        mode <= host.i_HData[2:0];
      if (rd_done)
        hdata <= io_RData[NIB_W-1:0];
      else if (get_shift)
        hdata <= r_nib;
    end
  end

  assign o_RAddr  = tgt ? i_TAddr : a_val;
  assign o_nROE   = tgt ? i_nTOE : (state != RD);
  assign o_nRWE   = tgt ? (i_nTWE | mode[MODE_WP]) : (state != WR);
  assign o_nReset = tgt;

  // Host mode drives the write buffer through WR and REC for hold time.
  assign r_drive  = tgt ? (!o_nRWE && o_nROE) : ((state == WR) || (state == REC));
  assign r_out    = tgt ? io_TData : w_val;
  assign t_drive  = tgt && !i_nTOE && i_nTWE;
  assign io_RData = r_drive ? r_out : 'z;
  assign io_TData = t_drive ? io_RData : 'z;

  assign host.o_HData = hdata;
  assign host.o_HBusy = !idle;
  assign host.o_HErr  = herr;

endmodule

// File: tb/tb_rom_emu_ctrl_p.sv
// Directed self-checking bench for rom_emu_ctrl_p with a behavioural SRAM
// on io_RData and a scripted target on io_TData.
module tb_rom_emu_ctrl_p;
  import rom_emu_pkg::*;

  logic        clk;
  logic        rst;
  logic [15:0] t_addr;
  logic        n_toe, n_twe;
  logic [15:0] r_addr;
  logic        n_roe, n_rwe, n_reset;
  wire  [7:0]  t_data;
  wire  [7:0]  r_data;
  logic        t_drv;
  logic [7:0]  t_val;
  logic [7:0]  mem [0:65535];
  int          tests;
  int          failed;

  rom_emu_ctrl_p_if #(.NIB_W(4)) hif ();

  rom_emu_ctrl_p #(
    .ADDR_W(16), .DATA_W(8), .NIB_W(4), .RD_CYC(2), .WR_CYC(3)
  ) dut (
    .i_HClk(clk), .i_Reset(rst), .host(hif),
    .i_TAddr(t_addr), .io_TData(t_data), .i_nTOE(n_toe), .i_nTWE(n_twe),
    .o_RAddr(r_addr), .io_RData(r_data), .o_nROE(n_roe), .o_nRWE(n_rwe),
    .o_nReset(n_reset)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM model: drives on read, captures on write, sampled mid-cycle.
  assign r_data = (!n_roe && n_rwe) ? mem[r_addr] : 'z;
  assign t_data = t_drv ? t_val : 'z;

  always @(negedge clk) begin
    if (!rst && !n_rwe)
      mem[r_addr] = r_data;
  end

  task automatic strobe(input logic [2:0] c, input logic [3:0] d);
    @(negedge clk);
    hif.i_HStb  = 1'b1;
    hif.i_HCmd  = c;
    hif.i_HData = d;
    @(negedge clk);
    hif.i_HStb  = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (hif.o_HBusy && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (hif.o_HBusy) begin
      tests++; failed++;
      $display("[TB] FAIL wait_idle: busy=%0b required 0 after 20 cycles", hif.o_HBusy);
    end
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    tests++; if (n_reset !== 1'b0) begin failed++; $display("[TB] FAIL reset_nreset: got %0b want 0", n_reset); end
    tests++; if (n_roe !== 1'b1) begin failed++; $display("[TB] FAIL reset_nroe: got %0b want 1", n_roe); end
    tests++; if (n_rwe !== 1'b1) begin failed++; $display("[TB] FAIL reset_nrwe: got %0b want 1", n_rwe); end
    tests++; if (hif.o_HErr !== 1'b0) begin failed++; $display("[TB] FAIL reset_herr: got %0b want 0", hif.o_HErr); end
    tests++; if (hif.o_HBusy !== 1'b0) begin failed++; $display("[TB] FAIL reset_hbusy: got %0b want 0", hif.o_HBusy); end
    tests++; if (hif.o_HData !== 4'h0) begin failed++; $display("[TB] FAIL reset_hdata: got %h want 0", hif.o_HData); end
    rst = 1'b0;
  endtask

  task automatic test_write_read();
    int roe_low = 0;
    strobe(CMD_SET_MODE, 4'h2);
    for (int i = 0; i < 4; i++) strobe(CMD_SET_ADDR, 4'hF);
    tests++; if (r_addr !== 16'hFFFF) begin failed++; $display("[TB] FAIL wr_addr_load: got %h want ffff", r_addr); end
    strobe(CMD_SET_DATA, 4'hA);
    strobe(CMD_SET_DATA, 4'h5);
    wait_idle();
    tests++; if (mem[16'hFFFF] !== 8'h5A) begin failed++; $display("[TB] FAIL wr_sram_data: got %h want 5a", mem[16'hFFFF]); end
    tests++; if (r_addr !== 16'h0000) begin failed++; $display("[TB] FAIL wr_addr_wrap: got %h want 0000", r_addr); end
    for (int i = 0; i < 4; i++) strobe(CMD_SET_ADDR, 4'hF);
    strobe(CMD_GET_DATA, 4'h0);
    for (int i = 0; i < 6; i++) begin
      if (!n_roe) roe_low++;
      @(negedge clk);
    end
    tests++; if (roe_low != 2) begin failed++; $display("[TB] FAIL rd_nroe_cycles: got %0d want 2", roe_low); end
    tests++; if (hif.o_HData !== 4'hA) begin failed++; $display("[TB] FAIL rd_nib0: got %h want a", hif.o_HData); end
    tests++; if (r_addr !== 16'hFFFF) begin failed++; $display("[TB] FAIL rd_addr_hold: got %h want ffff", r_addr); end
    strobe(CMD_GET_DATA, 4'h0);
    tests++; if (hif.o_HData !== 4'h5) begin failed++; $display("[TB] FAIL rd_nib1: got %h want 5", hif.o_HData); end
    tests++; if (r_addr !== 16'h0000) begin failed++; $display("[TB] FAIL rd_addr_wrap: got %h want 0000", r_addr); end
  endtask

  task automatic test_write_timing();
    int rwe_low = 0;
    int busy_cnt = 0;
    int bad_drive = 0;
    strobe(CMD_SET_MODE, 4'h0);
    strobe(CMD_SET_ADDR, 4'h1);
    strobe(CMD_SET_ADDR, 4'h2);
    strobe(CMD_SET_ADDR, 4'h3);
    strobe(CMD_SET_ADDR, 4'h4);
    strobe(CMD_SET_DATA, 4'h3);
    strobe(CMD_SET_DATA, 4'hC);
    for (int i = 0; i < 8; i++) begin
      if (!n_rwe) rwe_low++;
      if (hif.o_HBusy) begin
        busy_cnt++;
        if (r_data !== 8'hC3) bad_drive++;
      end
      @(negedge clk);
    end
    tests++; if (rwe_low != 3) begin failed++; $display("[TB] FAIL wt_nrwe_cycles: got %0d want 3", rwe_low); end
    tests++; if (busy_cnt != 4) begin failed++; $display("[TB] FAIL wt_busy_cycles: got %0d want 4", busy_cnt); end
    tests++; if (bad_drive != 0) begin failed++; $display("[TB] FAIL wt_rdata_drive: got %0d bad cycles want 0", bad_drive); end
    tests++; if (mem[16'h4321] !== 8'hC3) begin failed++; $display("[TB] FAIL wt_sram_data: got %h want c3", mem[16'h4321]); end
    tests++; if (r_addr !== 16'h4321) begin failed++; $display("[TB] FAIL wt_addr_noinc: got %h want 4321", r_addr); end
  endtask

  task automatic test_busy_violation();
    strobe(CMD_SET_DATA, 4'h0);
    @(negedge clk);
    hif.i_HStb = 1'b1; hif.i_HCmd = CMD_SET_DATA; hif.i_HData = 4'h1;
    @(negedge clk);
    hif.i_HCmd = CMD_GET_DATA;
    @(negedge clk);
    hif.i_HStb = 1'b0;
    tests++; if (hif.o_HErr !== 1'b1) begin failed++; $display("[TB] FAIL bv_herr_set: got %0b want 1", hif.o_HErr); end
    wait_idle();
    tests++; if (hif.o_HData !== 4'h5) begin failed++; $display("[TB] FAIL bv_get_ignored: got %h want 5", hif.o_HData); end
    strobe(CMD_NOP0, 4'h0);
    tests++; if (hif.o_HErr !== 1'b1) begin failed++; $display("[TB] FAIL bv_herr_sticky: got %0b want 1", hif.o_HErr); end
    strobe(CMD_RESET, 4'h0);
    tests++; if (hif.o_HErr !== 1'b0) begin failed++; $display("[TB] FAIL bv_herr_clear: got %0b want 0", hif.o_HErr); end
    tests++; if (r_addr !== 16'h0000) begin failed++; $display("[TB] FAIL bv_soft_reset_addr: got %h want 0000", r_addr); end
  endtask

  task automatic test_target();
    pulse_reset();
    strobe(CMD_SET_ADDR, 4'h0);
    strobe(CMD_SET_ADDR, 4'h1);
    strobe(CMD_SET_ADDR, 4'h0);
    strobe(CMD_SET_ADDR, 4'h0);
    strobe(CMD_SET_DATA, 4'h7);
    strobe(CMD_SET_DATA, 4'h7);
    wait_idle();
    strobe(CMD_SET_MODE, 4'h5);
    tests++; if (n_reset !== 1'b1) begin failed++; $display("[TB] FAIL tgt_nreset: got %0b want 1", n_reset); end
    t_addr = 16'h0010; n_toe = 1'b0; n_twe = 1'b1;
    @(negedge clk);
    tests++; if (r_addr !== 16'h0010) begin failed++; $display("[TB] FAIL tgt_raddr: got %h want 0010", r_addr); end
    tests++; if (t_data !== 8'h77) begin failed++; $display("[TB] FAIL tgt_read_data: got %h want 77", t_data); end
    n_toe = 1'b1; t_val = 8'h99; t_drv = 1'b1; n_twe = 1'b0;
    @(negedge clk);
    tests++; if (n_rwe !== 1'b1) begin failed++; $display("[TB] FAIL tgt_wp_nrwe: got %0b want 1", n_rwe); end
    @(negedge clk);
    tests++; if (mem[16'h0010] !== 8'h77) begin failed++; $display("[TB] FAIL tgt_wp_sram: got %h want 77", mem[16'h0010]); end
    strobe(CMD_SET_DATA, 4'h3);
    tests++; if (hif.o_HErr !== 1'b1) begin failed++; $display("[TB] FAIL tgt_host_err: got %0b want 1", hif.o_HErr); end
    tests++; if (hif.o_HBusy !== 1'b0) begin failed++; $display("[TB] FAIL tgt_host_ignored: got busy %0b want 0", hif.o_HBusy); end
    strobe(CMD_SET_MODE, 4'h1);
    tests++; if (n_rwe !== 1'b0) begin failed++; $display("[TB] FAIL tgt_nowp_nrwe: got %0b want 0", n_rwe); end
    tests++; if (r_data !== 8'h99) begin failed++; $display("[TB] FAIL tgt_write_data: got %h want 99", r_data); end
    @(negedge clk);
    n_twe = 1'b1; t_drv = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_read();
    pulse_reset();
    strobe(CMD_SET_ADDR, 4'h0);
    strobe(CMD_SET_ADDR, 4'h1);
    strobe(CMD_SET_ADDR, 4'h0);
    strobe(CMD_SET_ADDR, 4'h0);
    strobe(CMD_GET_DATA, 4'h0);
    tests++; if (n_roe !== 1'b0) begin failed++; $display("[TB] FAIL mr_in_read: got nroe %0b want 0", n_roe); end
    #1 rst = 1'b1;
    #1;
    tests++; if (n_roe !== 1'b1) begin failed++; $display("[TB] FAIL mr_nroe_release: got %0b want 1", n_roe); end
    tests++; if (hif.o_HBusy !== 1'b0) begin failed++; $display("[TB] FAIL mr_idle: got busy %0b want 0", hif.o_HBusy); end
    @(negedge clk);
    rst = 1'b0;
    strobe(CMD_SET_ADDR, 4'h0);
    strobe(CMD_SET_ADDR, 4'h1);
    strobe(CMD_SET_ADDR, 4'h0);
    strobe(CMD_SET_ADDR, 4'h0);
    strobe(CMD_GET_DATA, 4'h0);
    tests++; if (hif.o_HBusy !== 1'b1) begin failed++; $display("[TB] FAIL mr_ridx_zero: got busy %0b want 1", hif.o_HBusy); end
    wait_idle();
    tests++; if (hif.o_HData !== 4'h9) begin failed++; $display("[TB] FAIL mr_reread: got %h want 9", hif.o_HData); end
  endtask

  initial begin
    tests = 0;
    failed = 0;
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    rst = 1'b0;
    hif.i_HStb = 1'b0; hif.i_HCmd = CMD_NOP0; hif.i_HData = 4'h0;
    t_addr = 16'h0000; n_toe = 1'b1; n_twe = 1'b1;
    t_drv = 1'b0; t_val = 8'h00;
    test_reset();
    test_write_read();
    test_write_timing();
    test_busy_violation();
    test_target();
    test_reset_mid_read();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
